// File: rtl/sound_pkg.sv
// rtl/sound_pkg.sv - shared types and constants for the sound scheduler
package sound_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    GAP
  } sound_state_t;

  localparam int SOUND_CNT_W           = 8;
  localparam int SOUND_PLAY_FRAMES_DEF = 15;
  localparam int SOUND_GAP_FRAMES_DEF  = 2;

  // Index width for n requesters, never narrower than one bit.
  function automatic int sound_id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sound_scheduler_if.sv
// rtl/sound_scheduler_if.sv - request/grant bundle between game logic and the sound scheduler
interface sound_scheduler_if
  import sound_pkg::*;
#(
  parameter int NUMBER_OF_SOUNDS = 4
);

  localparam int ID_W = sound_id_w(NUMBER_OF_SOUNDS);

  logic                        enable;
  logic                        startOfFrame;
  logic [NUMBER_OF_SOUNDS-1:0] sound_requests;
  logic                        sound_active;
  logic [ID_W-1:0]             sound_id;
  logic                        start_pulse;
  logic                        done_pulse;
  logic [NUMBER_OF_SOUNDS-1:0] pending;

  modport master (
    output enable, startOfFrame, sound_requests,
    input  sound_active, sound_id, start_pulse, done_pulse, pending
  );

  modport slave (
    input  enable, startOfFrame, sound_requests,
    output sound_active, sound_id, start_pulse, done_pulse, pending
  );

endinterface

// File: rtl/sound_prio_enc.sv
// rtl/sound_prio_enc.sv - lowest-index-first priority encoder over the pending vector
module sound_prio_enc
  import sound_pkg::*;
#(
  parameter int N    = 4,
  parameter int ID_W = sound_id_w(N)
) (
  input  logic [N-1:0]    pending,
  output logic            any,
  output logic [ID_W-1:0] idx
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    any = |pending;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pending[i]) idx = ID_W'(i);
    end
  end

endmodule

// File: rtl/sound_scheduler.sv
// rtl/sound_scheduler.sv - fixed-priority one-shot sound arbiter; optional SOUND_PREEMPT_EN enables preemption
module sound_scheduler
  import sound_pkg::*;
#(
  parameter int NUMBER_OF_SOUNDS = 4,
  parameter int PLAY_FRAMES      = SOUND_PLAY_FRAMES_DEF,
  parameter int GAP_FRAMES       = SOUND_GAP_FRAMES_DEF
) (
  input  logic               clk,
  input  logic               rst,
  sound_scheduler_if.slave   bus
);

  localparam int ID_W = sound_id_w(NUMBER_OF_SOUNDS);
  localparam logic [SOUND_CNT_W-1:0] PLAY_CNT = SOUND_CNT_W'(PLAY_FRAMES);
  localparam logic [SOUND_CNT_W-1:0] GAP_CNT  = SOUND_CNT_W'(GAP_FRAMES);

  sound_state_t                state_q, state_d;
  logic [SOUND_CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUMBER_OF_SOUNDS-1:0] pending_q, pending_d;
  logic [NUMBER_OF_SOUNDS-1:0] grant_mask;
  logic                        active_q, active_d;
  logic                        start_q, start_d;
  logic                        done_q, done_d;
  logic [ID_W-1:0]             id_q, id_d;

  logic                        pend_any;
  logic [ID_W-1:0]             pend_idx;
  logic                        tick;
  logic                        preempt;

  sound_prio_enc #(
    .N    (NUMBER_OF_SOUNDS),
    .ID_W (ID_W)
  ) u_prio (
    .pending (pending_q),
    .any     (pend_any),
    .idx     (pend_idx)
  );

  // Frames only count while the game is running.
  assign tick = bus.enable & bus.startOfFrame;

`ifdef SOUND_PREEMPT_EN
  // A waiting sound of higher priority than the one playing cuts it short.
  assign preempt = pend_any && (pend_idx < id_q);
`else
  assign preempt = 1'b0;
`endif

  // Next-state, counter and pulse logic for the IDLE/PLAY/GAP sequencer.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    active_d   = active_q;
    id_d       = id_q;
    start_d    = 1'b0;
    done_d     = 1'b0;
    grant_mask = '0;
    case (state_q)
      IDLE: begin
        if (bus.enable && pend_any) begin
          state_d              = PLAY;
          cnt_d                = PLAY_CNT;
          start_d              = 1'b1;
          active_d             = 1'b1;
          id_d                 = pend_idx;
          grant_mask[pend_idx] = 1'b1;
        end
      end
      PLAY: begin
        if (bus.enable && preempt) begin
          // Aborted sound is dropped; the waiting one is granted from IDLE next edge.
          state_d  = IDLE;
          cnt_d    = '0;
          done_d   = 1'b1;
          active_d = 1'b0;
        end else if (tick && cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == SOUND_CNT_W'(1)) begin
            done_d   = 1'b1;
            active_d = 1'b0;
            if (GAP_FRAMES == 0) begin
              state_d = IDLE;
            end else begin
              state_d = GAP;
              cnt_d   = GAP_CNT;
            end
          end
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else if (tick) begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == SOUND_CNT_W'(1)) state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    // A new request on the grant edge wins over the clear so the sound replays.
    pending_d = (pending_q & ~grant_mask) | bus.sound_requests;
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pending_q <= '0;
      active_q  <= 1'b0;
      start_q   <= 1'b0;
      done_q    <= 1'b0;
      id_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      active_q  <= active_d;
      start_q   <= start_d;
      done_q    <= done_d;
      id_q      <= id_d;
    end
  end

  assign bus.sound_active = active_q & bus.enable;
  assign bus.sound_id     = id_q;
  assign bus.start_pulse  = start_q;
  assign bus.done_pulse   = done_q;
  assign bus.pending      = pending_q;

endmodule

// File: tb/tb_sound_scheduler.sv
// tb/tb_sound_scheduler.sv - directed vector bench for sound_scheduler (4 sounds, 3 play frames, 1 gap frame)
module tb_sound_scheduler;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  sound_scheduler_if #(.NUMBER_OF_SOUNDS(4)) bus ();

  sound_scheduler #(
    .NUMBER_OF_SOUNDS (4),
    .PLAY_FRAMES      (3),
    .GAP_FRAMES       (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       sof;
    logic [3:0] req;
    logic       act;
    logic [1:0] id;
    logic       st;
    logic       dn;
    logic [3:0] pend;
  } vec_t;

  vec_t vecs[$];

  task automatic v(input logic en, input logic sof, input logic [3:0] req,
                   input logic act, input logic [1:0] id, input logic st,
                   input logic dn, input logic [3:0] pend);
    vec_t r;
    r.en = en; r.sof = sof; r.req = req; r.act = act;
    r.id = id; r.st = st; r.dn = dn; r.pend = pend;
    vecs.push_back(r);
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d got %0h want %0h", nm, idx, act, exp);
    end
  endtask

  task automatic chk_all(input int idx, input logic act, input logic [1:0] id,
                         input logic st, input logic dn, input logic [3:0] pend);
    chk("sound_active", idx, 32'(bus.sound_active), 32'(act));
    chk("sound_id",     idx, 32'(bus.sound_id),     32'(id));
    chk("start_pulse",  idx, 32'(bus.start_pulse),  32'(st));
    chk("done_pulse",   idx, 32'(bus.done_pulse),   32'(dn));
    chk("pending",      idx, 32'(bus.pending),      32'(pend));
  endtask

  task automatic step(input logic en, input logic sof, input logic [3:0] req);
    bus.enable         = en;
    bus.startOfFrame   = sof;
    bus.sound_requests = req;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    bus.enable         = 1'b0;
    bus.startOfFrame   = 1'b0;
    bus.sound_requests = 4'b0000;

    // single request on bit 2
    v(1,0,4'b0100, 0,0,0,0,4'b0100);
    v(1,0,4'b0000, 1,2,1,0,4'b0000);
    v(1,1,4'b0000, 1,2,0,0,4'b0000);
    v(1,0,4'b0000, 1,2,0,0,4'b0000);
    v(1,1,4'b0000, 1,2,0,0,4'b0000);
    v(1,1,4'b0000, 0,2,0,1,4'b0000);
    v(1,0,4'b0000, 0,2,0,0,4'b0000);
    v(1,1,4'b0000, 0,2,0,0,4'b0000);
    // simultaneous requests 3 and 1
    v(1,0,4'b1010, 0,2,0,0,4'b1010);
    v(1,0,4'b0000, 1,1,1,0,4'b1000);
    v(1,1,4'b0000, 1,1,0,0,4'b1000);
    v(1,1,4'b0000, 1,1,0,0,4'b1000);
    v(1,1,4'b0000, 0,1,0,1,4'b1000);
    v(1,1,4'b0000, 0,1,0,0,4'b1000);
    v(1,0,4'b0000, 1,3,1,0,4'b0000);
    v(1,1,4'b0000, 1,3,0,0,4'b0000);
    v(1,1,4'b0000, 1,3,0,0,4'b0000);
    v(1,1,4'b0000, 0,3,0,1,4'b0000);
    v(1,1,4'b0000, 0,3,0,0,4'b0000);
    // set-while-granted on bit 0
    v(1,0,4'b0001, 0,3,0,0,4'b0001);
    v(1,0,4'b0001, 1,0,1,0,4'b0001);
    v(1,1,4'b0000, 1,0,0,0,4'b0001);
    v(1,1,4'b0000, 1,0,0,0,4'b0001);
    v(1,1,4'b0000, 0,0,0,1,4'b0001);
    v(1,1,4'b0000, 0,0,0,0,4'b0001);
    v(1,0,4'b0000, 1,0,1,0,4'b0000);
    // pause with 2 frames remaining, held for 5 frames
    v(1,1,4'b0000, 1,0,0,0,4'b0000);
    v(0,1,4'b0000, 0,0,0,0,4'b0000);
    v(0,1,4'b0000, 0,0,0,0,4'b0000);
    v(0,1,4'b0100, 0,0,0,0,4'b0100);
    v(0,1,4'b0000, 0,0,0,0,4'b0100);
    v(0,1,4'b0000, 0,0,0,0,4'b0100);
    v(1,0,4'b0000, 1,0,0,0,4'b0100);
    v(1,1,4'b0000, 1,0,0,0,4'b0100);
    v(1,1,4'b0000, 0,0,0,1,4'b0100);
    v(0,1,4'b0000, 0,0,0,0,4'b0100);
    v(1,1,4'b0000, 0,0,0,0,4'b0100);
    v(0,0,4'b0000, 0,0,0,0,4'b0100);
    v(1,0,4'b0000, 1,2,1,0,4'b0000);

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk_all(-1, 0, 0, 0, 0, 4'b0000);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].en, vecs[i].sof, vecs[i].req);
      chk_all(i, vecs[i].act, vecs[i].id, vecs[i].st, vecs[i].dn, vecs[i].pend);
    end

    // sound 2 is playing with 3 frames left; bit 0 arrives
    step(1,0,4'b0001);
    chk_all(100, 1, 2, 0, 0, 4'b0001);
`ifdef SOUND_PREEMPT_EN
    step(1,0,4'b0000);
    chk_all(101, 0, 2, 0, 1, 4'b0001);
    step(1,0,4'b0000);
    chk_all(102, 1, 0, 1, 0, 4'b0000);
`else
    step(1,0,4'b0000);
    chk_all(101, 1, 2, 0, 0, 4'b0001);
    step(1,1,4'b0000);
    step(1,1,4'b0000);
    chk_all(102, 1, 2, 0, 0, 4'b0001);
    step(1,1,4'b0000);
    chk_all(103, 0, 2, 0, 1, 4'b0001);
    step(1,1,4'b0000);
    chk_all(104, 0, 2, 0, 0, 4'b0001);
    step(1,0,4'b0000);
    chk_all(105, 1, 0, 1, 0, 4'b0000);
`endif

    // reset mid-play with requests pending
    step(1,0,4'b0110);
    chk_all(200, 1, 0, 0, 0, 4'b0110);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_all(201, 0, 0, 0, 0, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    step(1,0,4'b0000);
    chk_all(202, 0, 0, 0, 0, 4'b0000);
    step(1,1,4'b0000);
    chk_all(203, 0, 0, 0, 0, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sound_scheduler.md
# sound_scheduler

Arbitrates one-shot sound events (player hit, monster hit, missile fire, stage win, …) onto the single shared `sound_unit` tone channel. It latches request pulses from the game datapath, grants one sound at a time by fixed priority, and holds it for a frame-counted duration followed by a silent gap. It sits between the collision/game logic and `sound_unit`, replacing direct wiring of raw collision bits to the audio path.

## Interface
- `NUMBER_OF_SOUNDS`, default 4: number of requesters; legal range 1–16.
- `PLAY_FRAMES`, default 15: number of frames a granted sound plays; legal range 1–255.
- `GAP_FRAMES`, default 2: number of silent frames between consecutive sounds; legal range 0–255.
- `clk` input, 1 bit: system clock (the divided VGA clock).
- `rst` input, 1 bit: reset, asynchronous, active-high.
- `enable` input, 1 bit: low means paused; counters freeze and the output is muted.
- `startOfFrame` input, 1 bit: one-cycle frame tick.
- `sound_requests` input, `NUMBER_OF_SOUNDS` bits: one-cycle request pulses; index 0 has the highest priority.
- `sound_active` output, 1 bit: tone channel enabled.
- `sound_id` output, `ID_W` bits: index of the granted sound. `ID_W` is `$clog2(NUMBER_OF_SOUNDS)`, with a minimum of 1.
- `start_pulse` output, 1 bit: one cycle at the start of a grant.
- `done_pulse` output, 1 bit: one cycle when PLAY ends, whether by expiry or by preemption.
- `pending` output, `NUMBER_OF_SOUNDS` bits: latched, not-yet-granted requests.

## Operation
- **Reset values:** state IDLE; `pending` = 0; `sound_active` = 0; `sound_id` = 0; `start_pulse` = 0; `done_pulse` = 0; frame counter = 0.
- **Pending latch:**
  - Any request bit sets the corresponding `pending[i]` on the next edge. This happens regardless of state or `enable`.
  - A grant clears that sound's bit.
  - If a set and a clear hit the same bit in the same cycle, the set wins. The sound then replays after the current one.
  - Repeated requests while a bit is already pending merge into one.
- **State machine:**
  - **IDLE:** if `enable` is high and `pending` is non-zero, grant the lowest set index and go to PLAY. Load the counter with `PLAY_FRAMES`, pulse `start_pulse`, and set `sound_active`.
  - **PLAY:** each `startOfFrame` with `enable` high decrements the counter. When the counter reaches 0, pulse `done_pulse` and clear `sound_active`.
    - If `GAP_FRAMES` is 0, go directly to the IDLE decision on the same edge. A pending sound is then granted back-to-back, with the done and start pulses on consecutive cycles.
    - Otherwise load `GAP_FRAMES` and go to GAP.
  - **GAP:** each `startOfFrame` with `enable` high decrements the counter. When it reaches 0, go to IDLE.
- **Pause (`enable` low):**
  - The state and counter hold.
  - `sound_active` is forced to 0 combinationally from the registered flag.
  - No grants are issued.
  - When `enable` returns high, the sound resumes with the remaining frames.
- **Frame counting:** the first frame of PLAY is partial. Duration is counted in `startOfFrame` edges, so the played time lies between `PLAY_FRAMES`−1 and `PLAY_FRAMES` frames.
- **Counter:** 8 bits, and it never underflows.
- **`sound_id`:** holds its last value outside PLAY.

## Timing
- A request sampled at edge t sets `pending` at t. IDLE grants at t+1, so `start_pulse` and `sound_active` are high in the cycle after t+1. Request-to-sound latency is 2 clocks.
- `done_pulse` and the falling edge of `sound_active` occur on the edge that samples the final `startOfFrame` of PLAY.
- All outputs are registered except the `enable` mute gate on `sound_active`.
- Asserting `rst` mid-sound takes effect immediately: all outputs return to their reset values and pending requests are lost.

## Configuration
- **`SOUND_PREEMPT_EN` defined:**
  - In PLAY, if `pending` holds an index lower than `sound_id`, the current sound aborts.
  - `done_pulse` fires, the gap is skipped, and the higher-priority sound is granted on the next edge.
  - The aborted sound is not re-queued.
- **`SOUND_PREEMPT_EN` undefined:** a granted sound always plays to completion and priority applies only in IDLE.

## Structure
- **`sound_pkg`** holds:
  - the state enum `sound_state_t` {IDLE, PLAY, GAP};
  - `SOUND_CNT_W` = 8;
  - default constants `SOUND_PLAY_FRAMES_DEF` and `SOUND_GAP_FRAMES_DEF`.
- **Sub-module `sound_prio_enc`:** parameterised lowest-index-first priority encoder. Inputs are the `pending` vector. Outputs are `any` and `idx[ID_W-1:0]`. It is reused by the preemption compare.

## Test plan
- **Single request:** reset, `enable`=1, `PLAY_FRAMES`=3, `GAP_FRAMES`=1; pulse `sound_requests[2]` → 2 clocks later `start_pulse`=1, `sound_id`=2, `sound_active`=1. After 3 `startOfFrame` ticks, `done_pulse`=1, then GAP lasts 1 frame, then IDLE.
- **Simultaneous requests:** pulse bits 3 and 1 in the same cycle → sound 1 is granted first while `pending`=4'b1000. Sound 3 starts after sound 1's gap expires.
- **Set-while-granted:** during sound 0's grant cycle, pulse bit 0 again → `pending[0]` stays 1 and sound 0 replays after the gap.
- **Pause:** drop `enable` in PLAY with 2 frames remaining and hold it for 5 frames → `sound_active`=0 and the counter holds. On resume, exactly 2 more ticks occur before `done_pulse`.
- **Preemption (with `SOUND_PREEMPT_EN` defined):** while sound 3 plays, pulse bit 0 → `done_pulse`, then the next cycle gives `start_pulse` with `sound_id`=0 and `pending[3]`=0.
- **Reset mid-play:** assert `rst` in PLAY with `pending`=4'b0110 → all outputs are 0 asynchronously and `pending`=0 after `rst` deasserts.
